// File: rtl/ex_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit that owns the architectural HI/LO registers.
// Define MULDIV_FAST_MUL_EN to replace the shift-add multiplier with a single-cycle multiplier.
module ex_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] regaData,
    input  logic [WIDTH-1:0] regbData,
    input  logic             flush,
    input  logic             whi,
    input  logic             wlo,
    input  logic [WIDTH-1:0] wHiData,
    input  logic [WIDTH-1:0] wLoData,
    output logic             busy,
    output logic             done,
    output logic             divZero,
    output logic [WIDTH-1:0] hiData,
    output logic [WIDTH-1:0] loData
);

    localparam int unsigned W     = WIDTH;
    localparam int unsigned DW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    acc_q, acc_d;
    logic [W-1:0]     m_q, m_d;
    logic [W-1:0]     a_q, a_d;
    logic             div_q, div_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dz_q, dz_d;
    logic [W-1:0]     hi_q, hi_d;
    logic [W-1:0]     lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             divz_q, divz_d;

    logic             op_sgn;
    logic             accept;
    logic [W-1:0]     abs_a, abs_b;
    logic [W:0]       mul_sum, div_sh, div_trial;
    logic [W-1:0]     rem_raw, quo_raw, rem_fix, quo_fix;

    // Next-state, datapath and output computation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        m_d       = m_q;
        a_d       = a_q;
        div_d     = div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        hi_d      = whi ? wHiData : hi_q;
        lo_d      = wlo ? wLoData : lo_q;

        op_sgn    = ~op[0];
        abs_a     = (op_sgn && regaData[W-1]) ? -regaData : regaData;
        abs_b     = (op_sgn && regbData[W-1]) ? -regbData : regbData;
        accept    = start && !flush && (state_q == S_IDLE || state_q == S_DONE);

        mul_sum   = {1'b0, acc_q[DW-1:W]} + (acc_q[0] ? {1'b0, m_q} : '0);
        div_sh    = {acc_q[DW-1:W], acc_q[W-1]};
        div_trial = div_sh - {1'b0, m_q};
        rem_raw   = acc_q[DW-1:W];
        quo_raw   = acc_q[W-1:0];
        rem_fix   = neg_rem_q ? -rem_raw : rem_raw;
        quo_fix   = neg_res_q ? -quo_raw : quo_raw;

        case (state_q)
            S_MUL: begin
                acc_d = {mul_sum, acc_q[W-1:1]};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = S_FIX;
            end
            S_DIV: begin
                // Restoring step: a clear borrow bit means the divisor fits.
                if (!div_trial[W]) acc_d = {div_trial[W-1:0], acc_q[W-2:0], 1'b1};
                else               acc_d = {div_sh[W-1:0], acc_q[W-2:0], 1'b0};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = S_DIV == S_DIV ? S_FIX : S_FIX;
            end
            S_FIX: begin
                if (!div_q)    acc_d = neg_res_q ? -acc_q : acc_q;
                else if (dz_q) acc_d = {a_q, {W{1'b1}}};
                else           acc_d = {rem_fix, quo_fix};
                state_d = S_DONE;
            end
            S_DONE: begin
                if (!flush) begin
                    hi_d = acc_q[DW-1:W];
                    lo_d = acc_q[W-1:0];
                end
                state_d = S_IDLE;
            end
            default: ;
        endcase

        if (accept) begin
            a_d       = regaData;
            div_d     = op[1];
            neg_res_d = op_sgn && (regaData[W-1] ^ regbData[W-1]);
            neg_rem_d = op_sgn && regaData[W-1];
            dz_d      = (regbData == '0);
            cnt_d     = CNT_W'(W);
            if (op[1]) begin
                m_d     = abs_b;
                acc_d   = {W'(0), abs_a};
                state_d = S_DIV;
            end else begin
                m_d     = abs_a;
`ifdef MULDIV_FAST_MUL_EN
                acc_d   = DW'(abs_a) * DW'(abs_b);
                state_d = S_FIX;
`else
                acc_d   = {W'(0), abs_b};
                state_d = S_MUL;
`endif
            end
        end

        if (flush && state_q != S_IDLE) state_d = S_IDLE;

        busy_d = (state_d == S_MUL) || (state_d == S_DIV) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
        divz_d = (state_d == S_DONE) && div_q && dz_q;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            m_q       <= '0;
            a_q       <= '0;
            div_q     <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            divz_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            m_q       <= m_d;
            a_q       <= a_d;
            div_q     <= div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            divz_q    <= divz_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign divZero = divz_q;
    assign hiData  = hi_q;
    assign loData  = lo_q;

endmodule
